// File: rtl/ins_mem_burst_if.sv
`default_nettype none
// ============================================================================
// Module      : ins_mem_burst_if
// Description : Request/response bundle between the DPFU fetch control
//               (master) and the burst instruction memory (slave).
//               Request side : req_valid, req_ready, req_addr, req_count, flush
//               Response side: rsp_valid, rsp_ready, rsp_data, rsp_mask,
//                              rsp_last, remaining, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface ins_mem_burst_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int CNT_W  = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic [31:0]             req_addr;
  logic [CNT_W-1:0]        req_count;
  logic                    flush;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [LANES*DATA_W-1:0] rsp_data;
  logic [LANES-1:0]        rsp_mask;
  logic                    rsp_last;
  logic [CNT_W-1:0]        remaining;
  logic                    busy;

  modport master (
    output req_valid, req_addr, req_count, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_mask, rsp_last, remaining, busy
  );

  modport slave (
    input  req_valid, req_addr, req_count, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_mask, rsp_last, remaining, busy
  );
endinterface
`default_nettype wire

// File: rtl/ins_mem_burst.sv
`default_nettype none
// ============================================================================
// Module      : ins_mem_burst
// Description : Read-only instruction memory serving multi-beat burst fetches.
//               A (PC, count) request is accepted in IDLE, followed by LATENCY
//               idle cycles, then LANES-wide beats with lane masks and a last
//               flag. Honours rsp_ready backpressure; flush aborts at any time.
// Ports       : clk   - clock, rising edge
//               reset - synchronous active-high reset
//               bus   - ins_mem_burst_if.slave (request/response bundle)
// Revision    : 1.0 - initial release
// ============================================================================
module ins_mem_burst #(
  parameter int DATA_W  = 32,
  parameter int LANES   = 4,
  parameter int DEPTH   = 128,
  parameter int LATENCY = 3,
  parameter int CNT_W   = 4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  ins_mem_burst_if.slave bus
);

  localparam int IDX_W    = $clog2(DEPTH);
  localparam int LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LAT_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LAT  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [LANES*DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [LANES-1:0]        rsp_mask_q, rsp_mask_d;
  logic                    rsp_last_q, rsp_last_d;
  logic                    busy_q;

  // Read-only contents: entry k holds k.
  logic [DATA_W-1:0] mem [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign mem[k] = DATA_W'(k);
  end

  // Beat generator. Its source pointer is the current one, or the advanced
  // one when a non-last beat handshakes this cycle, so the following beat
  // can be registered with no bubble.
  logic                    adv;
  logic [CNT_W-1:0]        cur_n;
  logic [IDX_W-1:0]        src_idx;
  logic [CNT_W-1:0]        src_rem;
  logic [LANES*DATA_W-1:0] beat_data;
  logic [LANES-1:0]        beat_mask;
  logic                    beat_last;

  always_comb begin
    cur_n     = (32'(rem_q) < 32'(LANES)) ? rem_q : CNT_W'(LANES);
    adv       = (state_q == S_RESP) && rsp_valid_q && bus.rsp_ready && !rsp_last_q;
    src_idx   = adv ? idx_q + IDX_W'(cur_n) : idx_q;
    src_rem   = adv ? rem_q - cur_n : rem_q;
    beat_last = (32'(src_rem) <= 32'(LANES));
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [IDX_W-1:0] lane_idx;
    assign lane_idx      = src_idx + IDX_W'(i);
    assign beat_mask[i]  = (32'(src_rem) > 32'(i));
    assign beat_data[i*DATA_W +: DATA_W] = beat_mask[i] ? mem[lane_idx] : '0;
  end

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_mask_d  = rsp_mask_q;
    rsp_last_d  = rsp_last_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          idx_d     = bus.req_addr[IDX_W+1:2];
          rem_d     = bus.req_count;
          lat_cnt_d = '0;
          state_d   = (LATENCY > 0) ? S_LAT : S_RESP;
        end
      end
      S_LAT: begin
        if (lat_cnt_q == LAT_W'(LAT_LAST)) begin
          state_d = S_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (!rsp_valid_q || adv) begin
          // First beat after latency, or next beat after a handshake.
          idx_d       = src_idx;
          rem_d       = src_rem;
          rsp_valid_d = 1'b1;
          rsp_data_d  = beat_data;
          rsp_mask_d  = beat_mask;
          rsp_last_d  = beat_last;
        end else if (bus.rsp_ready) begin
          // Last beat consumed.
          state_d     = S_IDLE;
          rem_d       = '0;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_mask_d  = '0;
          rsp_last_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything except reset; a beat handshaking in the
    // same cycle is simply treated as consumed.
    if (bus.flush) begin
      state_d     = S_IDLE;
      lat_cnt_d   = '0;
      rem_d       = '0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = '0;
      rsp_mask_d  = '0;
      rsp_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_mask_q  <= '0;
      rsp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mask_q  <= rsp_mask_d;
      rsp_last_q  <= rsp_last_d;
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_mask  = rsp_mask_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.remaining = rem_q;
  assign bus.busy      = busy_q;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{bus.req_addr[31:IDX_W+2], bus.req_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_ins_mem_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_ins_mem_burst
// Description : Self-checking bench for ins_mem_burst. Expected beats are
//               queued when a request is issued; a monitor pops and compares
//               on every response handshake. A second LATENCY=0 instance
//               checks the zero-latency timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ins_mem_burst;
  localparam int DW = 32;
  localparam int LN = 4;
  localparam int CW = 4;
  localparam int BW = DW * LN;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ins_mem_burst_if #(.DATA_W(DW), .LANES(LN), .CNT_W(CW)) bus  ();
  ins_mem_burst_if #(.DATA_W(DW), .LANES(LN), .CNT_W(CW)) bus0 ();

  ins_mem_burst #(.DATA_W(DW), .LANES(LN), .DEPTH(128), .LATENCY(3), .CNT_W(CW))
    u_dut  (.clk(clk), .reset(reset), .bus(bus));
  ins_mem_burst #(.DATA_W(DW), .LANES(LN), .DEPTH(128), .LATENCY(0), .CNT_W(CW))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

  typedef struct {
    logic [BW-1:0] data;
    logic [LN-1:0] mask;
    logic          last;
    logic [CW-1:0] rem;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [BW-1:0] d, input logic [LN-1:0] m,
                               input logic l, input logic [CW-1:0] r);
    beat_t b;
    b.data = d; b.mask = m; b.last = l; b.rem = r;
    exp_q.push_back(b);
  endfunction

  // Scoreboard monitor: a beat is consumed on the edge following a cycle
  // where valid and ready are both high.
  always @(negedge clk) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got beat data %h expected no beat", bus.rsp_data);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("sb_data", bus.rsp_data, b.data);
        chk("sb_mask", BW'(bus.rsp_mask), BW'(b.mask));
        chk("sb_last", BW'(bus.rsp_last), BW'(b.last));
        chk("sb_remaining", BW'(bus.remaining), BW'(b.rem));
      end
    end
  end

  // Accept edge is the posedge inside this task; returns 1 time unit after it.
  task automatic send(input logic [31:0] addr, input logic [CW-1:0] cnt);
    bus.req_addr  = addr;
    bus.req_count = cnt;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int k);
    k = -1;
    for (int c = 1; c <= max; c++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        k = c;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    int ok;
    ok = 0;
    for (int c = 0; c < max; c++) begin
      if (!bus.busy && !bus.rsp_valid) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk(name, BW'(ok), BW'(1));
  endtask

  int lat;
  int vcnt;

  initial begin
    reset = 1'b1;
    bus.req_valid = 0; bus.req_addr = 0; bus.req_count = 0; bus.flush = 0; bus.rsp_ready = 1;
    bus0.req_valid = 0; bus0.req_addr = 0; bus0.req_count = 0; bus0.flush = 0; bus0.rsp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", BW'(bus.rsp_valid), BW'(0));
    chk("rst_remaining", BW'(bus.remaining), BW'(0));
    chk("rst_req_ready", BW'(bus.req_ready), BW'(1));
    chk("rst_busy", BW'(bus.busy), BW'(0));
    chk("rst_mask", BW'(bus.rsp_mask), BW'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Single instruction, latency 3 -> valid at accept+4.
    push(128'h0, 4'b0001, 1'b1, 4'd1);
    send(32'h0, 4'd1);
    wait_valid(20, lat);
    chk("lat_single", BW'(lat), BW'(4));
    wait_idle("idle_single", 20);

    // Two beats from index 4.
    push(128'h00000007_00000006_00000005_00000004, 4'b1111, 1'b0, 4'd6);
    push(128'h00000000_00000000_00000009_00000008, 4'b0011, 1'b1, 4'd2);
    send(32'h10, 4'd6);
    wait_valid(20, lat);
    chk("lat_multi", BW'(lat), BW'(4));
    wait_idle("idle_multi", 20);
    chk("multi_rem_end", BW'(bus.remaining), BW'(0));
    chk("multi_req_ready", BW'(bus.req_ready), BW'(1));

    // Wrap from index 126.
    push(128'h00000001_00000000_0000007f_0000007e, 4'b1111, 1'b1, 4'd4);
    send(32'h1F8, 4'd4);
    wait_idle("idle_wrap", 20);

    // Backpressure: first beat held 5 cycles, second beat back-to-back.
    bus.rsp_ready = 1'b0;
    push(128'h00000003_00000002_00000001_00000000, 4'b1111, 1'b0, 4'd8);
    push(128'h00000007_00000006_00000005_00000004, 4'b1111, 1'b1, 4'd4);
    send(32'h0, 4'd8);
    wait_valid(20, lat);
    chk("lat_bp", BW'(lat), BW'(4));
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_data", bus.rsp_data, 128'h00000003_00000002_00000001_00000000);
      chk("bp_hold_valid", BW'(bus.rsp_valid), BW'(1));
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_beat2_valid", BW'(bus.rsp_valid), BW'(1));
    chk("bp_beat2_data", bus.rsp_data, 128'h00000007_00000006_00000005_00000004);
    wait_idle("idle_bp", 20);

    // Flush during latency: nothing must come out.
    send(32'h0, 4'd8);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_lat_req_ready", BW'(bus.req_ready), BW'(1));
    chk("flush_lat_busy", BW'(bus.busy), BW'(0));
    vcnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.rsp_valid) vcnt++;
      @(posedge clk); #1;
    end
    chk("flush_lat_no_valid", BW'(vcnt), BW'(0));

    // Flush while first beat is stalled.
    bus.rsp_ready = 1'b0;
    send(32'h0, 4'd8);
    wait_valid(20, lat);
    chk("lat_flush_rsp", BW'(lat), BW'(4));
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_rsp_valid", BW'(bus.rsp_valid), BW'(0));
    chk("flush_rsp_rem", BW'(bus.remaining), BW'(0));
    chk("flush_rsp_mask", BW'(bus.rsp_mask), BW'(0));
    chk("flush_rsp_last", BW'(bus.rsp_last), BW'(0));
    chk("flush_rsp_req_ready", BW'(bus.req_ready), BW'(1));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Flush with a request in IDLE: not accepted.
    bus.flush = 1'b1;
    send(32'h0, 4'd2);
    bus.flush = 1'b0;
    chk("flush_idle_busy", BW'(bus.busy), BW'(0));

    // Zero count: one empty last beat after normal latency.
    push(128'h0, 4'b0000, 1'b1, 4'd0);
    send(32'h40, 4'd0);
    wait_valid(20, lat);
    chk("lat_zero", BW'(lat), BW'(4));
    wait_idle("idle_zero", 20);

    // LATENCY=0 instance: valid exactly one cycle after acceptance.
    bus0.req_addr  = 32'h8;
    bus0.req_count = 4'd2;
    bus0.req_valid = 1'b1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    chk("lat0_no_valid_yet", BW'(bus0.rsp_valid), BW'(0));
    @(posedge clk); #1;
    chk("lat0_valid", BW'(bus0.rsp_valid), BW'(1));
    chk("lat0_data", bus0.rsp_data, 128'h00000000_00000000_00000003_00000002);
    chk("lat0_mask", BW'(bus0.rsp_mask), BW'(4'b0011));
    chk("lat0_last", BW'(bus0.rsp_last), BW'(1));
    @(posedge clk); #1;
    chk("lat0_done", BW'(bus0.rsp_valid), BW'(0));

    repeat (2) @(posedge clk);
    chk("sb_drained", BW'(exp_q.size()), BW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/ins_mem_burst.md
Name: ins_mem_burst

Overview:
Parametrised instruction memory that serves multi-beat burst fetches to the DPFU fetch control. A request (PC, instruction count) is accepted with a valid/ready handshake. After a programmable latency the block returns the instructions in LANES-wide beats, with per-lane masks and a last flag. The response path honours backpressure and supports a flush. It adds generalised width, depth, latency, backpressure, address wrap and abort.

Parameters:
DATA_W, 32, instruction width in bits
LANES, 4, instructions per response beat (>=1)
DEPTH, 128, memory entries (power of 2)
LATENCY, 3, idle cycles between request acceptance and first beat (0 allowed)
CNT_W, 4, width of instruction-count fields (max request 2^CNT_W-1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  fetch request present
req_ready  out  1  block can accept request (high only in IDLE)
req_addr  in  32  byte PC; word index = req_addr[log2(DEPTH)+1:2], bits [1:0] ignored
req_count  in  CNT_W  number of instructions requested
flush  in  1  abort current/pending request
rsp_valid  out  1  beat on rsp_data valid
rsp_ready  in  1  consumer accepts beat
rsp_data  out  LANES*DATA_W  lane i = bits [i*DATA_W +: DATA_W], lane 0 = lowest address
rsp_mask  out  LANES  lane i carries a valid instruction
rsp_last  out  1  final beat of the request
remaining  out  CNT_W  instructions not yet handshaken on the response side
busy  out  1  request in progress (state != IDLE)

Behaviour:
- Reset: state IDLE; rsp_valid=0, rsp_data=0, rsp_mask=0, rsp_last=0, remaining=0, busy=0, req_ready=1; latency counter cleared. Reset wins over all other inputs. Reset mid-burst discards the request.
- Memory init: entry k = k (zero-extended to DATA_W). The array is read-only.
- States: IDLE, LAT, RESP.
- IDLE: on req_valid && req_ready, latch index, latch count, set remaining=req_count. Next state is LAT if LATENCY>0, otherwise RESP.
- LAT: counts LATENCY cycles, then moves to RESP. rsp_valid first rises exactly LATENCY+1 cycles after the acceptance edge (LATENCY=3: accept at edge T, rsp_valid high from T+4).
- RESP: beat size n = min(remaining, LANES). Lanes 0..n-1 = mem[(idx+i) mod DEPTH]. Lanes >= n are 0 and their mask bits are 0. rsp_last = (remaining <= LANES).
- rsp_valid is held, with data, mask and last stable, until rsp_ready is high.
- On a handshake of a non-last beat: idx += n (mod DEPTH), remaining -= n, and the next beat is presented the following cycle. Back-to-back beats are allowed, with no bubble.
- On a handshake of the last beat: rsp_valid=0 and remaining=0 next cycle, state returns to IDLE, and req_ready is high that cycle.
- req_count = 0: one beat with rsp_mask=0, rsp_data=0, rsp_last=1, after the normal latency.
- Address wrap: index arithmetic is modulo DEPTH. Bits of req_addr above the index are ignored.
- flush (highest priority after reset): in any state, next cycle state=IDLE, rsp_valid=0, remaining=0, mask/last cleared.
- flush together with req_valid in IDLE: the request is not accepted.
- A beat being handshaken in the same cycle as flush is considered consumed. No further beats follow.
- remaining, busy and all rsp_* outputs are registered.
- req_ready is combinational from state.

Test Plan:
- Reset: hold reset 2 cycles -> rsp_valid=0, remaining=0, req_ready=1. Then req 0x0, count 1, rsp_ready=1 -> rsp_valid at acceptance+4, lane0=0x0, mask=0001, last=1.
- Multi-beat: req_addr=0x10, count 6, rsp_ready=1 -> beat1 lanes {7,6,5,4}, mask 1111, last=0. Next cycle beat2 lanes {0,0,9,8}, mask 0011, last=1. remaining goes 6->2->0.
- Wrap: req_addr=0x1F8 (index 126), count 4 -> single beat lanes {1,0,127,126}, mask 1111, last=1.
- Backpressure: count 8, rsp_ready low for 5 cycles after the first rsp_valid -> beat1 data {3,2,1,0} stable throughout. Beat2 {7,6,5,4} follows on the cycle after the first handshake.
- Flush: count 8, assert flush during LAT -> no rsp_valid ever, req_ready high next cycle. Repeat with flush during beat1 while rsp_ready=0 -> rsp_valid drops next cycle, remaining=0.
- Zero count, and LATENCY=0 build: count 0 -> one beat with mask 0000, last=1. With LATENCY=0, rsp_valid is high exactly 1 cycle after acceptance.
